// File: rtl/fetch_sequencer.sv
// Fetch/execute phase sequencer: latches {instr,oprnd} from ROM, owns the PC and C/Z flags,
// and adds run / single-step control for the debug console.
module fetch_sequencer #(
    parameter int                  PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                step,
    input  logic [7:0]          rom_data,
    input  logic                incPC,
    input  logic                loadPC,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic                loadFlags,
    input  logic                alu_c,
    input  logic                alu_z,
    output logic [PC_WIDTH-1:0] rom_addr,
    output logic                phase,
    output logic [3:0]          instr,
    output logic [3:0]          oprnd,
    output logic                c_flag,
    output logic                z_flag,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } step_state_t;

    step_state_t         state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                phase_q, phase_d;
    logic [3:0]          instr_q, instr_d;
    logic [3:0]          oprnd_q, oprnd_d;
    logic                c_q, c_d;
    logic                z_q, z_d;
    logic                busy_q, busy_d;
    logic                step_pending;
    logic                adv;

    always_comb begin
        step_pending = (state_q != S_IDLE);
        // An execute phase is always finished, so a run drop mid-instruction halts at fetch.
        adv = run | step_pending | phase_q;

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (step && !run && !phase_q) state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);

        pc_d    = pc_q;
        phase_d = phase_q;
        instr_d = instr_q;
        oprnd_d = oprnd_q;
        c_d     = c_q;
        z_d     = z_q;
        if (adv) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                instr_d = rom_data[7:4];
                oprnd_d = rom_data[3:0];
            end else if (loadFlags) begin
                c_d = alu_c;
                z_d = alu_z;
            end
            if (loadPC) begin
                pc_d = jump_addr;
            end else if (incPC) begin
                pc_d = pc_q + PC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            phase_q <= 1'b0;
            instr_q <= 4'h0;
            oprnd_q <= 4'h0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            phase_q <= phase_d;
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
            c_q     <= c_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
        end
    end

    assign rom_addr = pc_q;
    assign phase    = phase_q;
    assign instr    = instr_q;
    assign oprnd    = oprnd_q;
    assign c_flag   = c_q;
    assign z_flag   = z_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized decoder/console traffic,
// all checked against a behavioural model of the instruction sequence.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run, step, incPC, loadPC, loadFlags, alu_c, alu_z;
    logic [11:0] jump_addr;
    logic [7:0]  rom_data;
    logic [11:0] rom_addr;
    logic        phase, c_flag, z_flag, busy;
    logic [3:0]  instr, oprnd;

    logic [7:0]  rom [0:4095];

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    logic [11:0] m_pc;
    logic        m_phase, m_c, m_z;
    logic [3:0]  m_instr, m_oprnd;
    int          m_steps_left;

    always #5 clock = ~clock;
    assign rom_data = rom[rom_addr];

    fetch_sequencer #(.PC_WIDTH(12), .RESET_VECTOR(12'h000)) dut (
        .clock(clock), .reset(reset), .run(run), .step(step), .rom_data(rom_data),
        .incPC(incPC), .loadPC(loadPC), .jump_addr(jump_addr), .loadFlags(loadFlags),
        .alu_c(alu_c), .alu_z(alu_z), .rom_addr(rom_addr), .phase(phase),
        .instr(instr), .oprnd(oprnd), .c_flag(c_flag), .z_flag(z_flag), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 12'h000; m_phase = 1'b0; m_c = 1'b0; m_z = 1'b0;
        m_instr = 4'h0; m_oprnd = 4'h0; m_steps_left = 0;
    endtask

    task automatic check_all(input string where);
        check({where, ".rom_addr"}, 32'(rom_addr), 32'(m_pc));
        check({where, ".phase"},    32'(phase),    32'(m_phase));
        check({where, ".instr"},    32'(instr),    32'(m_instr));
        check({where, ".oprnd"},    32'(oprnd),    32'(m_oprnd));
        check({where, ".c_flag"},   32'(c_flag),   32'(m_c));
        check({where, ".z_flag"},   32'(z_flag),   32'(m_z));
        check({where, ".busy"},     32'(busy),     32'(m_steps_left > 0));
    endtask

    // Called just after a falling edge: drive inputs, take one rising edge, update model, compare.
    task automatic do_cycle(input logic i_run, input logic i_step, input logic i_inc,
                            input logic i_ld, input logic [11:0] i_jump,
                            input logic i_lf, input logic i_c, input logic i_z,
                            input string where);
        bit adv;
        run = i_run; step = i_step; incPC = i_inc; loadPC = i_ld; jump_addr = i_jump;
        loadFlags = i_lf; alu_c = i_c; alu_z = i_z;
        @(posedge clock);
        // An instruction in execute phase always gets its execute edge.
        adv = i_run || (m_steps_left > 0) || m_phase;
        if (adv) begin
            if (!m_phase) {m_instr, m_oprnd} = rom[m_pc];
            else if (i_lf) begin m_c = i_c; m_z = i_z; end
            if (i_ld)       m_pc = i_jump;
            else if (i_inc) m_pc = m_pc + 12'd1;
            m_phase = !m_phase;
        end
        if (m_steps_left > 0) m_steps_left--;
        else if (i_step && !i_run && !m_phase && !adv) m_steps_left = 2;
        #1;
        check_all(where);
        $display("txn %-8s run=%0b step=%0b inc=%0b ld=%0b lf=%0b -> pc=%03h ph=%0b ins=%h%h cz=%0b%0b busy=%0b",
                 where, i_run, i_step, i_inc, i_ld, i_lf, rom_addr, phase, instr, oprnd,
                 c_flag, z_flag, busy);
        @(negedge clock);
    endtask

    initial begin
        logic [11:0] pc_save;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h4A;
        reset = 1'b1; run = 0; step = 0; incPC = 0; loadPC = 0; jump_addr = '0;
        loadFlags = 0; alu_c = 0; alu_z = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all("reset");
        reset = 1'b0;

        // fetch/execute of ROM[0]=4A with incPC in both phases
        do_cycle(1, 0, 1, 0, 12'h000, 0, 0, 0, "t1.e1");
        check("t1.instr", 32'(instr), 32'h4);
        check("t1.oprnd", 32'(oprnd), 32'hA);
        check("t1.phase1", 32'(phase), 32'h1);
        do_cycle(1, 0, 1, 0, 12'h000, 0, 0, 0, "t1.e2");
        check("t1.pc", 32'(rom_addr), 32'h2);
        check("t1.phase0", 32'(phase), 32'h0);

        // PC wrap and loadPC priority
        do_cycle(1, 0, 0, 1, 12'hFFF, 0, 0, 0, "t2.ld");
        do_cycle(1, 0, 1, 0, 12'h000, 0, 0, 0, "t2.wrap");
        check("t2.wrap", 32'(rom_addr), 32'h000);
        do_cycle(1, 0, 1, 0, 12'h000, 0, 0, 0, "t2.inc");
        do_cycle(1, 0, 1, 1, 12'h123, 0, 0, 0, "t2.prio");
        check("t2.prio", 32'(rom_addr), 32'h123);

        // flags load only in execute phase
        do_cycle(1, 0, 0, 0, 12'h000, 0, 0, 0, "t3.f");
        do_cycle(1, 0, 0, 0, 12'h000, 1, 1, 0, "t3.x");
        check("t3.c", 32'(c_flag), 32'h1);
        check("t3.z", 32'(z_flag), 32'h0);
        do_cycle(1, 0, 0, 0, 12'h000, 1, 0, 1, "t3.f0");
        check("t3.c_hold", 32'(c_flag), 32'h1);
        check("t3.z_hold", 32'(z_flag), 32'h0);
        do_cycle(1, 0, 0, 0, 12'h000, 0, 0, 0, "t3.x2");

        // single step while halted; second step while busy is ignored
        pc_save = rom_addr;
        do_cycle(0, 1, 1, 0, 12'h000, 0, 0, 0, "t4.req");
        check("t4.busy1", 32'(busy), 32'h1);
        do_cycle(0, 1, 1, 0, 12'h000, 0, 0, 0, "t4.f");
        check("t4.busy2", 32'(busy), 32'h1);
        do_cycle(0, 0, 1, 0, 12'h000, 0, 0, 0, "t4.x");
        check("t4.busy_end", 32'(busy), 32'h0);
        check("t4.pc", 32'(rom_addr), 32'(pc_save + 12'd2));
        do_cycle(0, 0, 1, 0, 12'h000, 0, 0, 0, "t4.frz1");
        do_cycle(0, 0, 1, 0, 12'h000, 0, 0, 0, "t4.frz2");
        check("t4.frozen", 32'(rom_addr), 32'(pc_save + 12'd2));

        // run dropped in execute phase finishes the instruction
        do_cycle(1, 0, 1, 0, 12'h000, 0, 0, 0, "t5.f");
        pc_save = rom_addr;
        do_cycle(0, 0, 1, 0, 12'h000, 0, 0, 0, "t5.x");
        check("t5.halt_ph", 32'(phase), 32'h0);
        check("t5.pc", 32'(rom_addr), 32'(pc_save + 12'd1));
        do_cycle(0, 0, 1, 0, 12'h000, 0, 0, 0, "t5.hold");

        // asynchronous reset mid-instruction
        do_cycle(1, 0, 1, 0, 12'h000, 1, 1, 1, "t5.pre");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("t5.areset");
        @(negedge clock);
        reset = 1'b0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic r_run;
            r_run = ($urandom_range(0, 3) != 0) ? (n % 64 < 32) : 1'($urandom);
            do_cycle(r_run, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 7) == 0), 12'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
